// File: rtl/spi_pkg.sv
// Shared SPI constants: operating-mode encodings and the idle value of the
// transfer counter.
package spi_pkg;

    localparam logic [1:0]  SPI_RUN  = 2'b00;
    localparam logic [1:0]  SPI_WAIT = 2'b01;
    localparam logic [1:0]  SPI_STOP = 2'b10;

    localparam logic [15:0] CNT_IDLE = 16'hFFFF;

endpackage

// File: rtl/spi_slave_select.sv
// SPI master slave-select generator: holds ss_o low for BaudRateDivisor_i*16
// PCLK cycles per requested transfer and pulses receive_data_o on completion.
module spi_slave_select
    import spi_pkg::*;
(
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [1:0]  spi_mode_i,
    input  logic        mstr_i,
    input  logic        spiswai_i,
    input  logic        send_data_i,
    input  logic [11:0] BaudRateDivisor_i,
    output logic        ss_o,
    output logic        receive_data_o,
    output logic        tip_o
);

    logic [15:0] cnt_q, cnt_d;
    logic [15:0] tgt_q, tgt_d;
    logic        ss_q, ss_d;
    logic        rx_q, rx_d;
    logic        enable;

    // Stop mode, wait mode with spiswai set, or slave operation all force idle.
    assign enable = mstr_i &&
                    ((spi_mode_i == SPI_RUN) ||
                     ((spi_mode_i == SPI_WAIT) && !spiswai_i));

    always_comb begin
        cnt_d = cnt_q;
        tgt_d = tgt_q;
        ss_d  = ss_q;
        rx_d  = 1'b0;
        if (!enable) begin
            cnt_d = CNT_IDLE;
            ss_d  = 1'b1;
        end else if (cnt_q == CNT_IDLE) begin
            if (send_data_i && (BaudRateDivisor_i != 12'd0)) begin
                cnt_d = 16'd0;
                tgt_d = {BaudRateDivisor_i, 4'b0000};
                ss_d  = 1'b0;
            end
        end else if (cnt_q == (tgt_q - 16'd1)) begin
            // Last low cycle: release ss and flag completion for one cycle.
            cnt_d = CNT_IDLE;
            ss_d  = 1'b1;
            rx_d  = 1'b1;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cnt_q <= CNT_IDLE;
            tgt_q <= 16'd0;
            ss_q  <= 1'b1;
            rx_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tgt_q <= tgt_d;
            ss_q  <= ss_d;
            rx_q  <= rx_d;
        end
    end

    assign ss_o           = ss_q;
    assign receive_data_o = rx_q;
    assign tip_o          = ~ss_q;

endmodule

// File: tb/tb_spi_slave_select.sv
// Self-checking bench for spi_slave_select: directed scenarios followed by a
// randomized phase, all compared cycle by cycle against a countdown model.
module tb_spi_slave_select;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [1:0]  spi_mode_i;
    logic        mstr_i;
    logic        spiswai_i;
    logic        send_data_i;
    logic [11:0] BaudRateDivisor_i;
    logic        ss_o;
    logic        receive_data_o;
    logic        tip_o;

    int total = 0;
    int bad   = 0;

    bit   mBusy = 1'b0;
    int   mLeft = 0;
    logic mSs   = 1'b1;
    logic mRx   = 1'b0;

    int lowRun     = 0;
    int lastLowRun = 0;
    int lowCycles  = 0;
    int pulses     = 0;

    spi_slave_select dut (
        .PCLK              (PCLK),
        .PRESET            (PRESET),
        .spi_mode_i        (spi_mode_i),
        .mstr_i            (mstr_i),
        .spiswai_i         (spiswai_i),
        .send_data_i       (send_data_i),
        .BaudRateDivisor_i (BaudRateDivisor_i),
        .ss_o              (ss_o),
        .receive_data_o    (receive_data_o),
        .tip_o             (tip_o)
    );

    always #5 PCLK = ~PCLK;

    function automatic bit modelEnable();
        return mstr_i && (spi_mode_i == 2'b00 ||
                          (spi_mode_i == 2'b01 && !spiswai_i));
    endfunction

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkCount(input string tag, input int obs, input int exp);
        total++;
        assert (obs == exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] mode, input logic mstr,
                                 input logic swai, input logic send,
                                 input logic [11:0] div);
        spi_mode_i        = mode;
        mstr_i            = mstr;
        spiswai_i         = swai;
        send_data_i       = send;
        BaudRateDivisor_i = div;
    endtask

    task automatic clearStats();
        lowRun     = 0;
        lastLowRun = 0;
        lowCycles  = 0;
        pulses     = 0;
    endtask

    // One PCLK edge: advance the model with the inputs seen at the edge, then
    // compare all outputs 1 time unit later.
    task automatic stepCycle();
        @(posedge PCLK);
        if (!modelEnable()) begin
            mBusy = 1'b0;
            mSs   = 1'b1;
            mRx   = 1'b0;
        end else if (!mBusy) begin
            mRx = 1'b0;
            if (send_data_i && BaudRateDivisor_i != 12'd0) begin
                mBusy = 1'b1;
                mLeft = int'(BaudRateDivisor_i) * 16;
                mSs   = 1'b0;
            end
        end else begin
            mLeft = mLeft - 1;
            mRx   = 1'b0;
            if (mLeft == 0) begin
                mBusy = 1'b0;
                mSs   = 1'b1;
                mRx   = 1'b1;
            end
        end
        #1;
        checkOutput("ss_o", ss_o, mSs);
        checkOutput("receive_data_o", receive_data_o, mRx);
        checkOutput("tip_o", tip_o, ~mSs);
        if (ss_o === 1'b0) begin
            lowRun++;
            lowCycles++;
        end else if (lowRun != 0) begin
            lastLowRun = lowRun;
            lowRun     = 0;
        end
        if (receive_data_o === 1'b1) pulses++;
    endtask

    task automatic runCycles(input int n);
        repeat (n) stepCycle();
    endtask

    initial begin
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b0, 12'd8);
        PRESET = 1'b1;
        #12;
        checkOutput("reset ss_o", ss_o, 1'b1);
        checkOutput("reset receive_data_o", receive_data_o, 1'b0);
        checkOutput("reset tip_o", tip_o, 1'b0);
        PRESET = 1'b0;
        runCycles(3);

        // Basic transfer, send held for 8 cycles.
        clearStats();
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b1, 12'd8);
        runCycles(8);
        send_data_i = 1'b0;
        runCycles(140);
        checkCount("div8 low length", lastLowRun, 128);
        checkCount("div8 pulses", pulses, 1);
        checkCount("div8 total low", lowCycles, 128);

        // Back-to-back transfers with divisor 1.
        clearStats();
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b1, 12'd1);
        runCycles(68);
        checkCount("div1 pulses", pulses, 4);
        checkCount("div1 low length", lastLowRun, 16);
        checkCount("div1 total low", lowCycles, 64);
        send_data_i = 1'b0;
        runCycles(20);

        // Disabled configurations ignore send.
        clearStats();
        applyStimulus(2'b01, 1'b1, 1'b1, 1'b1, 12'd1);
        runCycles(20);
        applyStimulus(2'b10, 1'b1, 1'b0, 1'b1, 12'd1);
        runCycles(20);
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b1, 12'd1);
        runCycles(20);
        applyStimulus(2'b11, 1'b1, 1'b0, 1'b1, 12'd1);
        runCycles(20);
        checkCount("disabled pulses", pulses, 0);
        checkCount("disabled low", lowCycles, 0);

        clearStats();
        applyStimulus(2'b01, 1'b1, 1'b0, 1'b1, 12'd1);
        stepCycle();
        send_data_i = 1'b0;
        runCycles(20);
        checkCount("wait mode pulses", pulses, 1);
        checkCount("wait mode low", lastLowRun, 16);

        // Abort by dropping mstr_i.
        clearStats();
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b1, 12'd8);
        stepCycle();
        send_data_i = 1'b0;
        runCycles(49);
        mstr_i = 1'b0;
        stepCycle();
        checkOutput("abort ss_o", ss_o, 1'b1);
        runCycles(10);
        mstr_i = 1'b1;
        runCycles(5);
        checkCount("abort pulses", pulses, 0);
        checkCount("abort low", lowCycles, 50);

        // Zero divisor, then divisor change mid-transfer.
        clearStats();
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b1, 12'd0);
        runCycles(10);
        checkCount("div0 low", lowCycles, 0);
        BaudRateDivisor_i = 12'd8;
        stepCycle();
        send_data_i       = 1'b0;
        BaudRateDivisor_i = 12'd2;
        runCycles(140);
        checkCount("div change low length", lastLowRun, 128);
        checkCount("div change pulses", pulses, 1);

        // Asynchronous reset mid-transfer.
        clearStats();
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b1, 12'd8);
        stepCycle();
        send_data_i = 1'b0;
        runCycles(29);
        PRESET = 1'b1;
        #2;
        checkOutput("async reset ss_o", ss_o, 1'b1);
        checkOutput("async reset tip_o", tip_o, 1'b0);
        checkOutput("async reset receive_data_o", receive_data_o, 1'b0);
        mBusy  = 1'b0;
        mSs    = 1'b1;
        mRx    = 1'b0;
        lowRun = 0;
        PRESET = 1'b0;
        runCycles(150);
        checkCount("post reset pulses", pulses, 0);
        checkCount("post reset low", lowCycles, 30);
        send_data_i = 1'b1;
        stepCycle();
        send_data_i = 1'b0;
        runCycles(130);
        checkCount("fresh send pulses", pulses, 1);
        checkCount("fresh send low", lastLowRun, 128);

        // Randomized phase against the model.
        clearStats();
        for (int i = 0; i < 1500; i++) begin
            if (i % 60 == 0) begin
                spi_mode_i        = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                mstr_i            = ($urandom_range(0, 7) != 0);
                spiswai_i         = 1'($urandom_range(0, 1));
                BaudRateDivisor_i = 12'($urandom_range(0, 3));
            end
            if (i % 7 == 0) BaudRateDivisor_i = 12'($urandom_range(0, 3));
            send_data_i = ($urandom_range(0, 3) == 0);
            stepCycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
